// File: rtl/jtag_sram_arbiter.sv
// jtag_sram_arbiter: shares one single-port SRAM between a toggle-handshake
// JTAG write path (tck domain, synchronized here) and a clk-domain core
// requester. One access is in flight at a time; ties alternate between sides.
module jtag_sram_arbiter #(
    parameter int AW     = 16,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          aclr,
    input  logic          jtag_req_tgl,
    input  logic [AW-1:0] jtag_addr,
    input  logic [DW-1:0] jtag_wdata,
    output logic          jtag_ack_tgl,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_wdata,
    output logic          sram_we,
    output logic          sram_re,
    input  logic [DW-1:0] sram_rdata,
    output logic          busy,
    output logic [15:0]   jtag_wr_count
);

    typedef enum logic [2:0] {IDLE, JTAG_WR, CORE_WR, CORE_RD, RD_WAIT} state_t;
    typedef enum logic {GRANT_JTAG, GRANT_CORE} side_t;

    state_t      state, next_state;
    side_t       last_grant, next_last_grant;
    logic        req_s1, req_s2, req_s3;
    logic        jtag_pending;
    logic [2:0]  rd_cnt;
    state_t      core_state;

    assign busy       = (state != IDLE);
    assign core_state = core_we ? CORE_WR : CORE_RD;

    // Next-state and round-robin arbitration between JTAG and core.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would infer a latch.
        next_state      = state;
        next_last_grant = last_grant;
        case (state)
            IDLE: begin
                if (jtag_pending && core_req) begin
                    next_state = (last_grant == GRANT_CORE) ? JTAG_WR : core_state;
                end else if (jtag_pending) begin
                    next_state = JTAG_WR;
                end else if (core_req) begin
                    next_state = core_state;
                end
            end
            JTAG_WR: next_state = IDLE;
            CORE_WR: next_state = IDLE;
            CORE_RD: next_state = RD_WAIT;
            RD_WAIT: if (rd_cnt == 3'd0) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (next_state == JTAG_WR) begin
            next_last_grant = GRANT_JTAG;
        end else if (next_state == CORE_WR || next_state == CORE_RD) begin
            next_last_grant = GRANT_CORE;
        end
    end

    // State register; last_grant starts at CORE so JTAG wins the first tie.
    always_ff @(posedge clk or negedge aclr) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!aclr) begin
            state      <= IDLE;
            last_grant <= GRANT_CORE;
        end else begin
            state      <= next_state;
            last_grant <= next_last_grant;
        end
    end

    // Two-flop synchronizer plus edge-detect flop for the JTAG request toggle.
    // Clearing on JTAG_WR entry wins over a coincident edge: any such edge is
    // a second toggle posted before ack and is merged into this write.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            req_s1       <= 1'b0;
            req_s2       <= 1'b0;
            req_s3       <= 1'b0;
            jtag_pending <= 1'b0;
        end else begin
            req_s1 <= jtag_req_tgl;
            req_s2 <= req_s1;
            req_s3 <= req_s2;
            if (next_state == JTAG_WR) begin
                jtag_pending <= 1'b0;
            end else if (req_s2 != req_s3) begin
                jtag_pending <= 1'b1;
            end
        end
    end

    // Registered SRAM strobes, grant, ack and read return, asserted in the
    // cycle the corresponding state is entered.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            sram_we       <= 1'b0;
            sram_re       <= 1'b0;
            sram_addr     <= '0;
            sram_wdata    <= '0;
            core_gnt      <= 1'b0;
            core_rvalid   <= 1'b0;
            core_rdata    <= '0;
            jtag_ack_tgl  <= 1'b0;
            jtag_wr_count <= '0;
            rd_cnt        <= '0;
        end else begin
            sram_we     <= 1'b0;
            sram_re     <= 1'b0;
            core_gnt    <= 1'b0;
            core_rvalid <= 1'b0;
            case (next_state)
                JTAG_WR: begin
                    sram_we      <= 1'b1;
                    sram_addr    <= jtag_addr;
                    sram_wdata   <= jtag_wdata;
                    jtag_ack_tgl <= ~jtag_ack_tgl;
                    if (jtag_wr_count != 16'hFFFF) jtag_wr_count <= jtag_wr_count + 16'd1;
                end
                CORE_WR: begin
                    sram_we    <= 1'b1;
                    sram_addr  <= core_addr;
                    sram_wdata <= core_wdata;
                    core_gnt   <= 1'b1;
                end
                CORE_RD: begin
                    sram_re   <= 1'b1;
                    sram_addr <= core_addr;
                    core_gnt  <= 1'b1;
                    rd_cnt    <= 3'(RD_LAT);
                end
                default: ;
            endcase
            // Count down the read latency; return data once it reaches zero.
            if (state == CORE_RD || (state == RD_WAIT && rd_cnt != 3'd0)) begin
                rd_cnt <= rd_cnt - 3'd1;
            end
            if (state == RD_WAIT && rd_cnt == 3'd0) begin
                core_rdata  <= sram_rdata;
                core_rvalid <= 1'b1;
            end
        end
    end

endmodule
